srt_quotient_converter: RTL and testbench

//  Stage directly downstream of the radix-2 SRT/non-restoring divider iteration unit.

---
 rtl/srt_div_pkg.sv | 20 ++
 rtl/srt_otf_update.sv | 34 +++
 rtl/srt_quotient_converter.sv | 178 +++++++++++++++++
 tb/tb_srt_quotient_converter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
// Shared definitions for the SRT divider back end: digit encodings, converter states, default widths.
package srt_div_pkg;

   localparam logic [1:0] DIG_POS  = 2'b01;
   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_NEG  = 2'b11;
   localparam logic [1:0] DIG_ILL  = 2'b10;

   localparam int unsigned QW_DEF = 4;
   localparam int unsigned RW_DEF = 9;
   localparam int unsigned DW_DEF = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      CORRECT = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/srt_otf_update.sv
// On-the-fly quotient conversion step: folds one signed digit into the Q/QM register pair.
module srt_otf_update
   import srt_div_pkg::*;
#(
   parameter int unsigned QW = QW_DEF
) (
   input  logic [QW-1:0] q_cur,
   input  logic [QW-1:0] qm_cur,
   input  logic [1:0]    digit,
   output logic [QW-1:0] q_nxt,
   output logic [QW-1:0] qm_nxt
);

   // MSBs shift out of the register and never affect the next value.
   logic unused_msb;
   assign unused_msb = q_cur[QW-1] ^ qm_cur[QW-1];

   always_comb begin
      q_nxt  = {q_cur[QW-2:0], 1'b0};
      qm_nxt = {qm_cur[QW-2:0], 1'b1};
      case (digit)
         DIG_POS: begin
            q_nxt  = {q_cur[QW-2:0], 1'b1};
            qm_nxt = {q_cur[QW-2:0], 1'b0};
         end
         DIG_NEG: begin
            q_nxt  = {qm_cur[QW-2:0], 1'b1};
            qm_nxt = {qm_cur[QW-2:0], 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/srt_quotient_converter.sv
// Radix-2 SRT quotient converter with remainder correction and valid/ready output.
// Optional digit/count checking enabled by defining SRT_QCONV_ERR_CHECK_EN.
module srt_quotient_converter
   import srt_div_pkg::*;
#(
   parameter int unsigned QW = QW_DEF,
   parameter int unsigned RW = RW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          digit_valid,
   input  logic [1:0]    digit,
   input  logic          digit_last,
   output logic          digit_ready,
   input  logic [RW-1:0] rem_in,
   input  logic [DW-1:0] div_in,
   output logic [QW-1:0] q,
   output logic [DW-1:0] r,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          err
);

   state_e        state_q, state_d;
   logic [QW-1:0] qreg_q, qreg_d;
   logic [QW-1:0] qm_q, qm_d;
   logic [DW-1:0] rem_hi_q, rem_hi_d;
   logic          rem_neg_q, rem_neg_d;
   logic [DW-1:0] div_q, div_d;
   logic [QW-1:0] q_q, q_d;
   logic [DW-1:0] r_q, r_d;
   logic          out_valid_q, out_valid_d;
   logic          digit_ready_q, digit_ready_d;
   logic [QW-1:0] q_nxt, qm_nxt;
   logic          accept;

   // Divisor is aligned to the top DW bits, so the low remainder bits never change the result.
   logic unused_rem_lo;
   assign unused_rem_lo = ^rem_in[RW-DW-1:0];

   srt_otf_update #(.QW(QW)) u_otf (
      .q_cur  (qreg_q),
      .qm_cur (qm_q),
      .digit  (digit),
      .q_nxt  (q_nxt),
      .qm_nxt (qm_nxt)
   );

   assign accept = digit_valid & digit_ready_q;

`ifdef SRT_QCONV_ERR_CHECK_EN
   localparam int unsigned CW = $clog2(QW) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ill_q, ill_d;
   logic          bad_last_q, bad_last_d;
   logic          err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      qreg_d        = qreg_q;
      qm_d          = qm_q;
      rem_hi_d      = rem_hi_q;
      rem_neg_d     = rem_neg_q;
      div_d         = div_q;
      q_d           = q_q;
      r_d           = r_q;
      out_valid_d   = out_valid_q;
      digit_ready_d = digit_ready_q;
`ifdef SRT_QCONV_ERR_CHECK_EN
      cnt_d         = cnt_q;
      ill_d         = ill_q;
      bad_last_d    = bad_last_q;
      err_d         = err_q;
`endif
      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               qreg_d = q_nxt;
               qm_d   = qm_nxt;
`ifdef SRT_QCONV_ERR_CHECK_EN
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (digit == DIG_ILL) ill_d = 1'b1;
               if (digit_last && (cnt_q != CW'(QW - 1))) bad_last_d = 1'b1;
`endif
               if (digit_last) begin
                  rem_hi_d      = rem_in[RW-1:RW-DW];
                  rem_neg_d     = rem_in[RW-1];
                  div_d         = div_in;
                  digit_ready_d = 1'b0;
                  state_d       = CORRECT;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         CORRECT: begin
            // Adding the aligned divisor only touches the top DW bits of the remainder.
            if (rem_neg_q) begin
               q_d = qm_q;
               r_d = rem_hi_q + div_q;
            end else begin
               q_d = qreg_q;
               r_d = rem_hi_q;
            end
`ifdef SRT_QCONV_ERR_CHECK_EN
            err_d = ill_q | bad_last_q;
`endif
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d   = 1'b0;
               digit_ready_d = 1'b1;
               qreg_d        = '0;
               qm_d          = '1;
`ifdef SRT_QCONV_ERR_CHECK_EN
               cnt_d         = '0;
               ill_d         = 1'b0;
               bad_last_d    = 1'b0;
               err_d         = 1'b0;
`endif
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         qreg_q        <= '0;
         qm_q          <= '1;
         rem_hi_q      <= '0;
         rem_neg_q     <= 1'b0;
         div_q         <= '0;
         q_q           <= '0;
         r_q           <= '0;
         out_valid_q   <= 1'b0;
         digit_ready_q <= 1'b1;
`ifdef SRT_QCONV_ERR_CHECK_EN
         cnt_q         <= '0;
         ill_q         <= 1'b0;
         bad_last_q    <= 1'b0;
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         qreg_q        <= qreg_d;
         qm_q          <= qm_d;
         rem_hi_q      <= rem_hi_d;
         rem_neg_q     <= rem_neg_d;
         div_q         <= div_d;
         q_q           <= q_d;
         r_q           <= r_d;
         out_valid_q   <= out_valid_d;
         digit_ready_q <= digit_ready_d;
`ifdef SRT_QCONV_ERR_CHECK_EN
         cnt_q         <= cnt_d;
         ill_q         <= ill_d;
         bad_last_q    <= bad_last_d;
         err_q         <= err_d;
`endif
      end
   end

   assign digit_ready = digit_ready_q;
   assign out_valid   = out_valid_q;
   assign q           = q_q;
   assign r           = r_q;

endmodule

// File: tb/tb_srt_quotient_converter.sv
// Directed vector bench for srt_quotient_converter; err expectations follow SRT_QCONV_ERR_CHECK_EN.
module tb_srt_quotient_converter;

   localparam int unsigned QW = 4;
   localparam int unsigned RW = 9;
   localparam int unsigned DW = 5;

`ifdef SRT_QCONV_ERR_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          digit_valid;
   logic [1:0]    digit;
   logic          digit_last;
   logic          digit_ready;
   logic [RW-1:0] rem_in;
   logic [DW-1:0] div_in;
   logic [QW-1:0] q;
   logic [DW-1:0] r;
   logic          out_valid;
   logic          out_ready;
   logic          err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0][1:0] dg;
      int              n;
      logic [RW-1:0]   rem;
      logic [DW-1:0]   dv;
      logic [QW-1:0]   exp_q;
      logic [DW-1:0]   exp_r;
      logic            exp_err;
   } vec_t;

   vec_t tab[7];

   srt_quotient_converter #(.QW(QW), .RW(RW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_last  (digit_last),
      .digit_ready (digit_ready),
      .rem_in      (rem_in),
      .div_in      (div_in),
      .q           (q),
      .r           (r),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                               input logic [1:0] d3, input int n, input logic [RW-1:0] rem,
                               input logic [DW-1:0] dv, input logic [QW-1:0] eq,
                               input logic [DW-1:0] er, input logic ee);
      vec_t v;
      v.dg[0] = d0; v.dg[1] = d1; v.dg[2] = d2; v.dg[3] = d3;
      v.n = n; v.rem = rem; v.dv = dv;
      v.exp_q = eq; v.exp_r = er; v.exp_err = ee;
      return v;
   endfunction

   // Presents n digits, one per accepted cycle; the final one carries digit_last.
   task automatic send_digits(input vec_t v, input int n, input logic mark_last);
      for (int i = 0; i < n; i++) begin
         int t;
         digit_valid = 1'b1;
         digit       = v.dg[i];
         digit_last  = mark_last && (i == n - 1);
         rem_in      = v.rem;
         div_in      = v.dv;
         t = 0;
         while (!digit_ready && t < 20) begin
            step();
            t++;
         end
         if (t == 20) chk("digit_ready_timeout", 32'(digit_ready), 32'd1);
         step();
      end
      digit_valid = 1'b0;
      digit_last  = 1'b0;
      digit       = 2'b00;
   endtask

   task automatic wait_result(input vec_t v, input string tag);
      chk({tag, "_lat_n1"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_correct"}, 32'(digit_ready), 32'd0);
      step();
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_q"}, 32'(q), 32'(v.exp_q));
      chk({tag, "_r"}, 32'(r), 32'(v.exp_r));
      chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(digit_ready), 32'd1);
   endtask

   initial begin
      logic [QW-1:0] q_hold;
      logic [DW-1:0] r_hold;

      tab[0] = mk(2'b01, 2'b00, 2'b11, 2'b01, 4, 9'h020, 5'b10000, 4'd7,  5'd2,  1'b0);
      tab[1] = mk(2'b01, 2'b01, 2'b01, 2'b01, 4, 9'h1F0, 5'b10000, 4'd14, 5'd15, 1'b0);
      tab[2] = mk(2'b00, 2'b00, 2'b00, 2'b00, 4, 9'h000, 5'b10000, 4'd0,  5'd0,  1'b0);
      tab[3] = mk(2'b11, 2'b11, 2'b11, 2'b11, 4, 9'h1C0, 5'b10011, 4'd0,  5'd15, 1'b0);
      tab[4] = mk(2'b01, 2'b11, 2'b00, 2'b01, 4, 9'h0A5, 5'b10001, 4'd5,  5'd10, 1'b0);
      tab[5] = mk(2'b01, 2'b10, 2'b00, 2'b01, 4, 9'h010, 5'b10000, 4'd9,  5'd1,  ERR_ON);
      tab[6] = mk(2'b01, 2'b01, 2'b00, 2'b00, 2, 9'h040, 5'b10000, 4'd3,  5'd4,  ERR_ON);

      rst = 1'b1; digit_valid = 1'b0; digit = 2'b00; digit_last = 1'b0;
      rem_in = '0; div_in = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_r", 32'(r), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_digit_ready", 32'(digit_ready), 32'd1);

      for (int k = 0; k < 7; k++) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         send_digits(tab[k], tab[k].n, 1'b1);
         wait_result(tab[k], tag);
         handshake(tag);
      end

      // Backpressure: hold the result for five cycles with a competing digit presented.
      send_digits(tab[0], 4, 1'b1);
      wait_result(tab[0], "bp");
      q_hold = q;
      r_hold = r;
      digit_valid = 1'b1;
      digit       = 2'b01;
      digit_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_valid_hold", 32'(out_valid), 32'd1);
         chk("bp_q_hold", 32'(q), 32'(q_hold));
         chk("bp_r_hold", 32'(r), 32'(r_hold));
         chk("bp_no_ready", 32'(digit_ready), 32'd0);
      end
      digit_valid = 1'b0;
      digit_last  = 1'b0;
      handshake("bp");
      step();
      chk("bp_no_stray_result", 32'(out_valid), 32'd0);

      // Reset mid-division discards partial Q/QM.
      send_digits(tab[1], 2, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_ready", 32'(digit_ready), 32'd1);
      send_digits(tab[0], 4, 1'b1);
      wait_result(tab[0], "midrst");
      handshake("midrst");

      // Back-to-back divisions with the consumer always ready.
      send_digits(tab[0], 4, 1'b1);
      wait_result(tab[0], "b2b_a");
      handshake("b2b_a");
      send_digits(tab[1], 4, 1'b1);
      wait_result(tab[1], "b2b_b");
      handshake("b2b_b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
